// File: rtl/keccak_rej_sampler.sv
// Kyber uniform rejection sampler ("Parse") fed by the keccak squeeze stream.
// A 128-bit MSB-aligned byte buffer yields two 12-bit candidates per 3-byte group.
module keccak_rej_sampler #(
  parameter int N_COEF  = 256,
  parameter int KYBER_Q = 3329,
  localparam int CW     = $clog2(N_COEF + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [63:0]   i_word,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [11:0]   o_coef0,
  output logic [11:0]   o_coef1,
  output logic [1:0]    o_coef_valid,
  output logic [CW-1:0] o_cnt,
  output logic          o_done,
  output logic          o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N_COEF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_COEF);
  localparam logic [11:0]   Q_BOUND  = 12'(KYBER_Q);

  state_t        state_q, state_d;
  logic [127:0]  sbuf_q, sbuf_d;
  logic [7:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   coef0_q, coef0_d;
  logic [11:0]   coef1_q, coef1_d;
  logic [1:0]    vld_q, vld_d;
  logic          done_q, done_d;

  logic          consume, handshake, finish;
  logic [7:0]    b0, b1, b2;
  logic [11:0]   cand1, cand2;
  logic          acc1, acc2;
  logic [11:0]   lane0, lane1;
  logic [1:0]    lane_vld;
  logic [CW-1:0] cnt_next;
  logic [127:0]  shifted;
  logic [7:0]    fill_rem;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: every flop is updated with <= so all registers see pre-edge values
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_RUN;
      S_RUN:  if (finish)  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (ready is purely a function of the registered fill)
  always_comb begin
    o_busy  = (state_q == S_RUN);
    o_ready = (state_q == S_IDLE) || (fill_q <= 8'd64);
  end

  // ---------------------------------------------------------------------------
  // Candidate extraction from the head of the buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    consume   = (state_q == S_RUN) && (fill_q >= 8'd24);
    handshake = i_valid && o_ready;
    b0        = sbuf_q[127:120];
    b1        = sbuf_q[119:112];
    b2        = sbuf_q[111:104];
    cand1     = {b1[3:0], b0};
    cand2     = {b2, b1[7:4]};
    acc1      = consume && (cand1 < Q_BOUND);
    acc2      = consume && (cand2 < Q_BOUND);
  end

  // Lane packing: accepted values fill lane 0 first; the last free slot takes one only
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches)
    lane_vld = 2'b00;
    lane0    = coef0_q;
    lane1    = coef1_q;
    if (acc1) begin
      lane0    = cand1;
      lane_vld = 2'b01;
      if (acc2 && (cnt_q != CNT_LAST)) begin
        lane1    = cand2;
        lane_vld = 2'b11;
      end
    end else if (acc2) begin
      lane0    = cand2;
      lane_vld = 2'b01;
    end
    cnt_next = cnt_q + CW'(lane_vld[0]) + CW'(lane_vld[1]);
    finish   = (state_q == S_RUN) && (cnt_next == CNT_FULL);
  end

  // ---------------------------------------------------------------------------
  // Buffer, counter and output-lane next values
  // ---------------------------------------------------------------------------
  always_comb begin
    shifted  = consume ? (sbuf_q << 24) : sbuf_q;
    fill_rem = consume ? (fill_q - 8'd24) : fill_q;

    sbuf_d   = sbuf_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    coef0_d  = lane0;
    coef1_d  = lane1;
    vld_d    = lane_vld;
    done_d   = finish;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sbuf_d = '0;
          fill_d = '0;
          cnt_d  = '0;
        end
      end
      S_RUN: begin
        sbuf_d = shifted;
        fill_d = fill_rem;
        cnt_d  = cnt_next;
        // New word lands directly below the bits that survive this edge
        if (handshake) begin
          sbuf_d = shifted | ({i_word, 64'd0} >> fill_rem);
          fill_d = fill_rem + 8'd64;
        end
        if (finish) begin
          sbuf_d = '0;
          fill_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sbuf_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      coef0_q <= '0;
      coef1_q <= '0;
      vld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      sbuf_q  <= sbuf_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      coef0_q <= coef0_d;
      coef1_q <= coef1_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign o_coef0      = coef0_q;
  assign o_coef1      = coef1_q;
  assign o_coef_valid = vld_q;
  assign o_cnt        = cnt_q;
  assign o_done       = done_q;

endmodule
